decode_regfile_stage: RTL
=========================

Name: decode_regfile_stage

Overview:
Parametrised decode/register-read pipeline stage. Splits a 32-bit RV instruction into fields, reads two source operands from an internal NREGS x XLEN register file and registers everything into one output stage under a valid/ready handshake. Adds the following over a plain parser+regfile pair:
- a pending-write scoreboard with RAW/WAW stall;
- writeback-to-read bypass;
- a hard-wired zero register;
- flush.

The stage sits between fetch and execute; the writeback port comes from the end of the pipeline.

Parameters:
XLEN, 64, register/data width in bits.
NREGS, 32, number of architectural registers (power of 2, 2..32); index width AW = clog2(NREGS), fields truncated to AW bits.
WB_BYPASS, 1, 1 = same-cycle writeback data forwarded to reads and clears hazard; 0 = no forwarding (stall one extra cycle).

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-high reset.
in_valid  input  1  instruction present.
in_ready  output  1  stage accepts instruction this cycle.
instruction  input  32  raw instruction.
out_valid  output  1  decoded bundle valid.
out_ready  input  1  downstream accepts bundle.
out_opcode  output  7  instr[6:0].
out_rd  output  5  instr[11:7].
out_funct3  output  3  instr[14:12].
out_rs1  output  5  instr[19:15].
out_rs2  output  5  instr[24:20].
out_funct7  output  7  instr[31:25].
out_rdata1  output  XLEN  operand rs1.
out_rdata2  output  XLEN  operand rs2.
out_writes_rd  output  1  instruction writes a nonzero rd.
wb_valid  input  1  writeback strobe.
wb_rd  input  5  writeback register.
wb_data  input  XLEN  writeback value.
flush  input  1  synchronous pipeline kill.

Behaviour:
- Reset (asynchronous, active-high; clock is clk):
  - all registers = 0, all pending bits = 0;
  - out_valid = 0, all out_* fields = 0;
  - in_ready = 0 while reset is high.
- Decode:
  - writes_rd = opcode in {0110011, 0010011, 0000011, 1101111, 1100111, 0110111, 0010111, 0111011, 0011011} and rd != 0.
  - uses_rs1 = opcode not in {0110111, 0010111, 1101111}.
  - uses_rs2 = opcode in {0110011, 0111011, 0100011, 1100011}.
- Register file:
  - register 0 always reads 0; writes to it are ignored.
  - Writes occur at the clk edge when wb_valid=1, with wb_data written to wb_rd.
- Scoreboard:
  - pending[r] is set at issue when writes_rd, with r = rd.
  - pending[r] is cleared at the clk edge when wb_valid=1 and wb_rd=r.
  - If set and clear target the same r in one cycle, set wins.
  - pending[0] is always 0.
- src_clear(s):
  - true when s=0, or pending[s]=0;
  - also true when WB_BYPASS=1, wb_valid=1 and wb_rd=s.
- Hazard (combinational):
  - (uses_rs1 and not src_clear(rs1)), or
  - (uses_rs2 and not src_clear(rs2)), or
  - (writes_rd and pending[rd] and not (wb_valid and wb_rd=rd)).
  - The last term is the WAW check; it releases on writeback regardless of WB_BYPASS.
- Handshake and issue:
  - in_ready = !reset and !flush and !hazard and (!out_valid or out_ready).
  - issue = in_valid and in_ready.
  - Latency: exactly 1 cycle from issue to out_valid.
- Output register:
  - On issue it loads all fields, writes_rd and operands; out_valid=1.
  - Else if out_ready: out_valid=0.
  - Else it holds; all out_* are stable while out_valid=1 and out_ready=0.
- Operand read at issue:
  - 0 if src=0;
  - else wb_data if WB_BYPASS=1, wb_valid=1 and wb_rd=src;
  - else the stored register value.
- Flush (highest priority):
  - out_valid cleared, all pending bits cleared, no issue that cycle.
  - A wb write in the same cycle still updates the register file.
- Throughput: 1 instruction/cycle with no hazard and out_ready held at 1.
- wb_rd / rd bits at or above AW are ignored (index truncated).

Test Plan:
- Reset mid-operation: out_valid=1 and pending[5]=1 when reset asserts asynchronously -> out_valid=0, pending all 0, x5 reads 0 immediately without a clock edge.
- Back-to-back independent: addi x1; addi x2; add x3,x1? … use add x3,x4,x5 with out_ready=1 -> three bundles on consecutive cycles with correct fields; out_writes_rd=1 on each.
- RAW stall: issue addi x1,x0,7 (0x00700093), then add x2,x1,x1 -> in_ready=0.
  - Stays 0 until wb_valid=1, wb_rd=1, wb_data=7.
  - WB_BYPASS=1: issues in that same cycle with out_rdata1=out_rdata2=7.
  - WB_BYPASS=0: issues one cycle later, reading 7 from the register file.
- x0 handling: wb_valid=1, wb_rd=0, wb_data=0xDEAD, then add x3,x0,x0 -> out_rdata1=0, no stall, out_writes_rd=1; addi x0 -> out_writes_rd=0, no pending set.
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0 and outputs hold for 5 cycles; out_ready=1 then accepts the next instruction the same cycle.
- Flush: pending[1]=1 and out_valid=1, pulse flush -> next cycle out_valid=0, pending clear, add x2,x1,x1 issues without stall.

Source files
------------

// File: rtl/decode_regfile_stage.sv
// decode_regfile_stage: RV instruction decode + register read.
// Scoreboard stall, writeback bypass, hard-wired x0, flush.
module decode_regfile_stage #(
    parameter int XLEN      = 64,
    parameter int NREGS     = 32,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_opcode,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_rdata1,
    output logic [XLEN-1:0] out_rdata2,
    output logic            out_writes_rd,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush
);
    localparam int AW = $clog2(NREGS);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_R32  = 7'b0111011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_I32  = 7'b0011011;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_AUI  = 7'b0010111;
    localparam logic [6:0] OP_ST   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [6:0]      funct7;
        logic [XLEN-1:0] rdata1;
        logic [XLEN-1:0] rdata2;
        logic            writes_rd;
    } id_ex_t;

    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [AW-1:0]   rdi;
    logic [AW-1:0]   s1;
    logic [AW-1:0]   s2;
    logic [AW-1:0]   wbi;
    logic            wr_op;
    logic            writes_rd;
    logic            uses_rs1;
    logic            uses_rs2;
    logic [NREGS-1:0] pend;
    logic [NREGS-1:0] pend_nxt;
    logic [XLEN-1:0] rf [NREGS];
    logic            byp1;
    logic            byp2;
    logic            clr1;
    logic            clr2;
    logic            wb_hit_rd;
    logic            hazard;
    logic            issue;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    id_ex_t          ex_d;
    id_ex_t          ex_q;

    assign opcode = instruction[6:0];
    assign rd     = instruction[11:7];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign rdi    = rd[AW-1:0];
    assign s1     = rs1[AW-1:0];
    assign s2     = rs2[AW-1:0];
    assign wbi    = wb_rd[AW-1:0];

    // opcode class -> destination / source usage
    always_comb begin
        wr_op    = 1'b0;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b0;
        unique case (opcode)
            OP_R, OP_R32: begin
                wr_op    = 1'b1;
                uses_rs2 = 1'b1;
            end
            OP_I, OP_I32, OP_LD, OP_JALR: begin
                wr_op = 1'b1;
            end
            OP_JAL, OP_LUI, OP_AUI: begin
                wr_op    = 1'b1;
                uses_rs1 = 1'b0;
            end
            OP_ST, OP_BR: begin
                uses_rs2 = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign writes_rd = wr_op && (rd != 5'd0);

    assign wb_hit_rd = wb_valid && (wbi == rdi);
    assign byp1 = WB_BYPASS && wb_valid && (wbi == s1);
    assign byp2 = WB_BYPASS && wb_valid && (wbi == s2);
    assign clr1 = (s1 == '0) || !pend[s1] || byp1;
    assign clr2 = (s2 == '0) || !pend[s2] || byp2;

    // WAW releases on writeback even without bypass
    assign hazard = (uses_rs1 && !clr1)
                 || (uses_rs2 && !clr2)
                 || (writes_rd && pend[rdi] && !wb_hit_rd);

    assign in_ready = !reset && !flush && !hazard
                   && (!out_valid || out_ready);
    assign issue = in_valid && in_ready;

    assign rd1 = (s1 == '0) ? '0 : byp1 ? wb_data : rf[s1];
    assign rd2 = (s2 == '0) ? '0 : byp2 ? wb_data : rf[s2];

    assign ex_d = '{
        opcode:    opcode,
        rd:        rd,
        funct3:    instruction[14:12],
        rs1:       rs1,
        rs2:       rs2,
        funct7:    instruction[31:25],
        rdata1:    rd1,
        rdata2:    rd2,
        writes_rd: writes_rd
    };

    // scoreboard update: flush clears, set beats same-cycle clear
    always_comb begin
        pend_nxt = pend;
        if (flush) begin
            pend_nxt = '0;
        end else begin
            if (wb_valid) pend_nxt[wbi] = 1'b0;
            if (issue && writes_rd) pend_nxt[rdi] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
    end

    // pending-write bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pend <= '0;
        else       pend <= pend_nxt;
    end

    // register file write port; x0 never written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (wb_valid && (wbi != '0)) begin
            rf[wbi] <= wb_data;
        end
    end

    // output bundle register with valid/ready hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            ex_q      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (issue) begin
            out_valid <= 1'b1;
            ex_q      <= ex_d;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign out_opcode    = ex_q.opcode;
    assign out_rd        = ex_q.rd;
    assign out_funct3    = ex_q.funct3;
    assign out_rs1       = ex_q.rs1;
    assign out_rs2       = ex_q.rs2;
    assign out_funct7    = ex_q.funct7;
    assign out_rdata1    = ex_q.rdata1;
    assign out_rdata2    = ex_q.rdata2;
    assign out_writes_rd = ex_q.writes_rd;

endmodule
